// File: rtl/reorder_buffer_pkg.sv
// Shared constants, types and small helpers for the reorder buffer.
//
// ROB ids run 1..ROB_SIZE; id 0 (ZERO_ROB) means "no producer". Entries are
// stored at index id-1, so the helpers below convert between the external
// id space and the internal slot index space.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int IDX_W    = $clog2(ROB_SIZE);

  typedef logic [4:0]       rob_id_t;
  typedef logic [31:0]      data_t;
  typedef logic [31:0]      addr_t;
  typedef logic [4:0]       reg_pos_t;
  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [IDX_W:0]   rob_count_t;

  localparam rob_id_t    ZERO_ROB       = 5'd0;
  localparam rob_id_t    MAX_ROB_ID     = rob_id_t'(ROB_SIZE);
  localparam rob_idx_t   LAST_IDX       = rob_idx_t'(ROB_SIZE - 1);
  localparam rob_count_t FULL_COUNT     = rob_count_t'(ROB_SIZE);
  // Two slots of slack: one dispatch may already be in flight when fetch
  // sees the stop request.
  localparam rob_count_t FULL_THRESHOLD = rob_count_t'(ROB_SIZE - 2);
  localparam reg_pos_t   ZERO_REG       = 5'd0;

  // True when id names a real entry (not ZERO_ROB, not out of range).
  function automatic logic id_valid(input rob_id_t id);
    return (id != ZERO_ROB) && (id <= MAX_ROB_ID);
  endfunction

  function automatic rob_idx_t id_to_idx(input rob_id_t id);
    return rob_idx_t'(id - rob_id_t'(1));
  endfunction

  function automatic rob_id_t idx_to_id(input rob_idx_t idx);
    return rob_id_t'(idx) + rob_id_t'(1);
  endfunction

  function automatic rob_idx_t next_idx(input rob_idx_t idx);
    return (idx == LAST_IDX) ? '0 : idx + rob_idx_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer.
//
// Allocates ROB ids to dispatched instructions, captures results from the
// RS and LS common data buses, answers operand-readiness queries and retires
// at most one entry per cycle in program order. A retiring jump whose actual
// direction differs from its prediction raises a one-cycle rollback and
// flushes every entry.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; low freezes all state and outputs
//   *_from_dsp               dispatch request and operand queries
//   rob_id_to_dsp            id the next dispatch receives
//   Q*_ready_to_dsp/V*_...   readiness/value of the queried producers
//   *_from_rs_cdb            RS result bus (also carries jump outcome)
//   *_from_ls_cdb            LS result bus
//   full_to_if               stop fetching
//   commit_*_to_reg          register-file commit pulse
//   commit_*_to_lsb          store commit pulse
//   rollback_flag, target_pc_to_if   flush broadcast and redirect pc
//   bp_ena, bp_pc, bp_taken  branch predictor update pulse
//
// Handshake: dispatch is valid-only. An asserted ena_from_dsp is accepted on
// the edge where rdy is high, unless a rollback is being decided or is being
// broadcast (wrong-path instruction), or the buffer holds ROB_SIZE entries and
// nothing retires that cycle. The dispatcher is expected to honour full_to_if,
// so the last case never happens in normal use. The CDBs are valid-only too.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,

  input  logic     ena_from_dsp,
  input  reg_pos_t rd_from_dsp,
  input  logic     is_jump_from_dsp,
  input  logic     is_store_from_dsp,
  input  logic     predicted_jump_from_dsp,
  input  addr_t    pc_from_dsp,
  output rob_id_t  rob_id_to_dsp,

  input  rob_id_t  Q1_from_dsp,
  input  rob_id_t  Q2_from_dsp,
  output logic     Q1_ready_to_dsp,
  output logic     Q2_ready_to_dsp,
  output data_t    V1_result_to_dsp,
  output data_t    V2_result_to_dsp,

  input  logic     valid_from_rs_cdb,
  input  rob_id_t  rob_id_from_rs_cdb,
  input  data_t    result_from_rs_cdb,
  input  logic     jump_flag_from_rs_cdb,
  input  addr_t    target_pc_from_rs_cdb,

  input  logic     valid_from_ls_cdb,
  input  rob_id_t  rob_id_from_ls_cdb,
  input  data_t    result_from_ls_cdb,

  output logic     full_to_if,

  output logic     commit_ena_to_reg,
  output reg_pos_t commit_rd_to_reg,
  output data_t    commit_value_to_reg,
  output rob_id_t  commit_rob_id_to_reg,

  output logic     commit_store_to_lsb,
  output rob_id_t  commit_rob_id_to_lsb,

  output logic     rollback_flag,
  output addr_t    target_pc_to_if,

  output logic     bp_ena,
  output addr_t    bp_pc,
  output logic     bp_taken
);

  // Per-entry state, one register array per field.
  logic     busy_q         [ROB_SIZE];
  logic     ready_q        [ROB_SIZE];
  reg_pos_t rd_q           [ROB_SIZE];
  data_t    value_q        [ROB_SIZE];
  addr_t    pc_q           [ROB_SIZE];
  logic     is_jump_q      [ROB_SIZE];
  logic     is_store_q     [ROB_SIZE];
  logic     predicted_q    [ROB_SIZE];
  logic     actual_taken_q [ROB_SIZE];
  addr_t    target_pc_q    [ROB_SIZE];

  rob_idx_t   head_q;
  rob_idx_t   tail_q;
  rob_count_t count_q;

  logic commit_fire;
  logic mispredict;
  logic dispatch_fire;
  logic rs_hit;
  logic ls_hit;

  // ---------------------------------------------------------------------
  // Combinational decisions
  // ---------------------------------------------------------------------
  assign commit_fire = busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && is_jump_q[head_q] &&
                       (actual_taken_q[head_q] != predicted_q[head_q]);

  // A dispatch arriving while the flush is being decided or broadcast
  // belongs to the wrong path and is dropped.
  assign dispatch_fire = ena_from_dsp && !mispredict && !rollback_flag &&
                         ((count_q != FULL_COUNT) || commit_fire);

  assign rs_hit = valid_from_rs_cdb && id_valid(rob_id_from_rs_cdb) &&
                  busy_q[id_to_idx(rob_id_from_rs_cdb)];
  assign ls_hit = valid_from_ls_cdb && id_valid(rob_id_from_ls_cdb) &&
                  busy_q[id_to_idx(rob_id_from_ls_cdb)];

  assign rob_id_to_dsp = idx_to_id(tail_q);
  assign full_to_if    = (count_q >= FULL_THRESHOLD);

  // Operand queries read the stored state only; same-cycle CDB forwarding
  // is the dispatcher's job.
  always_comb begin
    Q1_ready_to_dsp  = 1'b0;
    V1_result_to_dsp = '0;
    if (id_valid(Q1_from_dsp)) begin
      Q1_ready_to_dsp  = ready_q[id_to_idx(Q1_from_dsp)];
      V1_result_to_dsp = value_q[id_to_idx(Q1_from_dsp)];
    end
  end

  always_comb begin
    Q2_ready_to_dsp  = 1'b0;
    V2_result_to_dsp = '0;
    if (id_valid(Q2_from_dsp)) begin
      Q2_ready_to_dsp  = ready_q[id_to_idx(Q2_from_dsp)];
      V2_result_to_dsp = value_q[id_to_idx(Q2_from_dsp)];
    end
  end

  // ---------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      commit_ena_to_reg    <= 1'b0;
      commit_rd_to_reg     <= '0;
      commit_value_to_reg  <= '0;
      commit_rob_id_to_reg <= '0;
      commit_store_to_lsb  <= 1'b0;
      commit_rob_id_to_lsb <= '0;
      rollback_flag        <= 1'b0;
      target_pc_to_if      <= '0;
      bp_ena               <= 1'b0;
      bp_pc                <= '0;
      bp_taken             <= 1'b0;
    end else if (rdy) begin
      // Pulses drop unless re-asserted below.
      commit_ena_to_reg   <= 1'b0;
      commit_store_to_lsb <= 1'b0;
      rollback_flag       <= 1'b0;
      bp_ena              <= 1'b0;

      // LS first so that the RS write wins when both buses name one entry.
      if (ls_hit) begin
        ready_q[id_to_idx(rob_id_from_ls_cdb)] <= 1'b1;
        value_q[id_to_idx(rob_id_from_ls_cdb)] <= result_from_ls_cdb;
      end
      if (rs_hit) begin
        ready_q[id_to_idx(rob_id_from_rs_cdb)]        <= 1'b1;
        value_q[id_to_idx(rob_id_from_rs_cdb)]        <= result_from_rs_cdb;
        actual_taken_q[id_to_idx(rob_id_from_rs_cdb)] <= jump_flag_from_rs_cdb;
        target_pc_q[id_to_idx(rob_id_from_rs_cdb)]    <= target_pc_from_rs_cdb;
      end

      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= next_idx(head_q);
        if (is_store_q[head_q]) begin
          commit_store_to_lsb  <= 1'b1;
          commit_rob_id_to_lsb <= idx_to_id(head_q);
        end else begin
          if (rd_q[head_q] != ZERO_REG) begin
            commit_ena_to_reg    <= 1'b1;
            commit_rd_to_reg     <= rd_q[head_q];
            commit_value_to_reg  <= value_q[head_q];
            commit_rob_id_to_reg <= idx_to_id(head_q);
          end
          if (is_jump_q[head_q]) begin
            bp_ena   <= 1'b1;
            bp_pc    <= pc_q[head_q];
            bp_taken <= actual_taken_q[head_q];
          end
        end
      end

      // Written after the commit so that a full-wrap dispatch into the slot
      // being retired this cycle ends up busy.
      if (dispatch_fire) begin
        busy_q[tail_q]      <= 1'b1;
        ready_q[tail_q]     <= 1'b0;
        rd_q[tail_q]        <= rd_from_dsp;
        pc_q[tail_q]        <= pc_from_dsp;
        is_jump_q[tail_q]   <= is_jump_from_dsp;
        is_store_q[tail_q]  <= is_store_from_dsp;
        predicted_q[tail_q] <= predicted_jump_from_dsp;
        tail_q              <= next_idx(tail_q);
      end

      case ({dispatch_fire, commit_fire})
        2'b10:   count_q <= count_q + rob_count_t'(1);
        2'b01:   count_q <= count_q - rob_count_t'(1);
        default: count_q <= count_q;
      endcase

      // Flush overrides every pointer and entry update above.
      if (mispredict) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          busy_q[i]  <= 1'b0;
          ready_q[i] <= 1'b0;
        end
        head_q          <= '0;
        tail_q          <= '0;
        count_q         <= '0;
        rollback_flag   <= 1'b1;
        target_pc_to_if <= target_pc_q[head_q];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ena_from_dsp;
  logic [4:0]  rd_from_dsp;
  logic        is_jump_from_dsp;
  logic        is_store_from_dsp;
  logic        predicted_jump_from_dsp;
  logic [31:0] pc_from_dsp;
  logic [4:0]  rob_id_to_dsp;
  logic [4:0]  Q1_from_dsp;
  logic [4:0]  Q2_from_dsp;
  logic        Q1_ready_to_dsp;
  logic        Q2_ready_to_dsp;
  logic [31:0] V1_result_to_dsp;
  logic [31:0] V2_result_to_dsp;
  logic        valid_from_rs_cdb;
  logic [4:0]  rob_id_from_rs_cdb;
  logic [31:0] result_from_rs_cdb;
  logic        jump_flag_from_rs_cdb;
  logic [31:0] target_pc_from_rs_cdb;
  logic        valid_from_ls_cdb;
  logic [4:0]  rob_id_from_ls_cdb;
  logic [31:0] result_from_ls_cdb;
  logic        full_to_if;
  logic        commit_ena_to_reg;
  logic [4:0]  commit_rd_to_reg;
  logic [31:0] commit_value_to_reg;
  logic [4:0]  commit_rob_id_to_reg;
  logic        commit_store_to_lsb;
  logic [4:0]  commit_rob_id_to_lsb;
  logic        rollback_flag;
  logic [31:0] target_pc_to_if;
  logic        bp_ena;
  logic [31:0] bp_pc;
  logic        bp_taken;

  int pass_cnt;
  int total_cnt;

  reorder_buffer dut (
    .clk                     (clk),
    .rst                     (rst),
    .rdy                     (rdy),
    .ena_from_dsp            (ena_from_dsp),
    .rd_from_dsp             (rd_from_dsp),
    .is_jump_from_dsp        (is_jump_from_dsp),
    .is_store_from_dsp       (is_store_from_dsp),
    .predicted_jump_from_dsp (predicted_jump_from_dsp),
    .pc_from_dsp             (pc_from_dsp),
    .rob_id_to_dsp           (rob_id_to_dsp),
    .Q1_from_dsp             (Q1_from_dsp),
    .Q2_from_dsp             (Q2_from_dsp),
    .Q1_ready_to_dsp         (Q1_ready_to_dsp),
    .Q2_ready_to_dsp         (Q2_ready_to_dsp),
    .V1_result_to_dsp        (V1_result_to_dsp),
    .V2_result_to_dsp        (V2_result_to_dsp),
    .valid_from_rs_cdb       (valid_from_rs_cdb),
    .rob_id_from_rs_cdb      (rob_id_from_rs_cdb),
    .result_from_rs_cdb      (result_from_rs_cdb),
    .jump_flag_from_rs_cdb   (jump_flag_from_rs_cdb),
    .target_pc_from_rs_cdb   (target_pc_from_rs_cdb),
    .valid_from_ls_cdb       (valid_from_ls_cdb),
    .rob_id_from_ls_cdb      (rob_id_from_ls_cdb),
    .result_from_ls_cdb      (result_from_ls_cdb),
    .full_to_if              (full_to_if),
    .commit_ena_to_reg       (commit_ena_to_reg),
    .commit_rd_to_reg        (commit_rd_to_reg),
    .commit_value_to_reg     (commit_value_to_reg),
    .commit_rob_id_to_reg    (commit_rob_id_to_reg),
    .commit_store_to_lsb     (commit_store_to_lsb),
    .commit_rob_id_to_lsb    (commit_rob_id_to_lsb),
    .rollback_flag           (rollback_flag),
    .target_pc_to_if         (target_pc_to_if),
    .bp_ena                  (bp_ena),
    .bp_pc                   (bp_pc),
    .bp_taken                (bp_taken)
  );

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Advance one edge, then drop the per-cycle valids.
  task automatic cycle();
    @(posedge clk);
    #1;
    ena_from_dsp      = 1'b0;
    valid_from_rs_cdb = 1'b0;
    valid_from_ls_cdb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [4:0] rd, input logic jmp,
                                input logic st, input logic pred,
                                input logic [31:0] pc);
    ena_from_dsp            = 1'b1;
    rd_from_dsp             = rd;
    is_jump_from_dsp        = jmp;
    is_store_from_dsp       = st;
    predicted_jump_from_dsp = pred;
    pc_from_dsp             = pc;
  endtask

  task automatic drive_rs(input logic [4:0] id, input logic [31:0] res,
                          input logic taken, input logic [31:0] tgt);
    valid_from_rs_cdb     = 1'b1;
    rob_id_from_rs_cdb    = id;
    result_from_rs_cdb    = res;
    jump_flag_from_rs_cdb = taken;
    target_pc_from_rs_cdb = tgt;
  endtask

  task automatic drive_ls(input logic [4:0] id, input logic [31:0] res);
    valid_from_ls_cdb  = 1'b1;
    rob_id_from_ls_cdb = id;
    result_from_ls_cdb = res;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    Q1_from_dsp = 5'd1;
    total_cnt++;
    if (rob_id_to_dsp !== 5'd1)
      $display("FAIL reset_rob_id got %0d exp 1", rob_id_to_dsp);
    else pass_cnt++;
    total_cnt++;
    if (full_to_if !== 1'b0)
      $display("FAIL reset_full got %b exp 0", full_to_if);
    else pass_cnt++;
    total_cnt++;
    if ({commit_ena_to_reg, commit_store_to_lsb, rollback_flag, bp_ena} !== 4'b0000)
      $display("FAIL reset_pulses got %b exp 0000",
               {commit_ena_to_reg, commit_store_to_lsb, rollback_flag, bp_ena});
    else pass_cnt++;
    total_cnt++;
    if ({target_pc_to_if, commit_value_to_reg} !== 64'd0)
      $display("FAIL reset_data got %h/%h exp 0/0", target_pc_to_if, commit_value_to_reg);
    else pass_cnt++;
    total_cnt++;
    if (Q1_ready_to_dsp !== 1'b0)
      $display("FAIL reset_query got %b exp 0", Q1_ready_to_dsp);
    else pass_cnt++;
  endtask

  task automatic test_single_commit();
    do_reset();
    drive_dispatch(5'd5, 1'b0, 1'b0, 1'b0, 32'h1000);
    cycle();
    total_cnt++;
    if (rob_id_to_dsp !== 5'd2)
      $display("FAIL single_next_id got %0d exp 2", rob_id_to_dsp);
    else pass_cnt++;
    Q1_from_dsp = 5'd1;
    #1;
    total_cnt++;
    if (Q1_ready_to_dsp !== 1'b0)
      $display("FAIL single_not_ready got %b exp 0", Q1_ready_to_dsp);
    else pass_cnt++;
    drive_rs(5'd1, 32'h2A, 1'b0, 32'h0);
    cycle();
    Q2_from_dsp = 5'd0;
    #1;
    total_cnt++;
    if ({Q1_ready_to_dsp, V1_result_to_dsp} !== {1'b1, 32'h2A})
      $display("FAIL single_query got %b/%h exp 1/2a", Q1_ready_to_dsp, V1_result_to_dsp);
    else pass_cnt++;
    total_cnt++;
    if ({Q2_ready_to_dsp, V2_result_to_dsp} !== 33'd0)
      $display("FAIL query_zero got %b/%h exp 0/0", Q2_ready_to_dsp, V2_result_to_dsp);
    else pass_cnt++;
    total_cnt++;
    if (commit_ena_to_reg !== 1'b0)
      $display("FAIL single_early_commit got %b exp 0", commit_ena_to_reg);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({commit_ena_to_reg, commit_rd_to_reg, commit_value_to_reg, commit_rob_id_to_reg}
        !== {1'b1, 5'd5, 32'h2A, 5'd1})
      $display("FAIL single_commit got %b/%0d/%h/%0d exp 1/5/2a/1", commit_ena_to_reg,
               commit_rd_to_reg, commit_value_to_reg, commit_rob_id_to_reg);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (commit_ena_to_reg !== 1'b0)
      $display("FAIL single_pulse got %b exp 0", commit_ena_to_reg);
    else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    do_reset();
    drive_dispatch(5'd3, 1'b0, 1'b0, 1'b0, 32'h2000);
    cycle();
    drive_dispatch(5'd4, 1'b0, 1'b0, 1'b0, 32'h2004);
    cycle();
    drive_rs(5'd2, 32'h22, 1'b0, 32'h0);
    cycle();
    drive_rs(5'd1, 32'h11, 1'b0, 32'h0);
    cycle();
    total_cnt++;
    if (commit_ena_to_reg !== 1'b0)
      $display("FAIL ooo_no_early got %b exp 0", commit_ena_to_reg);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({commit_ena_to_reg, commit_rd_to_reg, commit_value_to_reg, commit_rob_id_to_reg}
        !== {1'b1, 5'd3, 32'h11, 5'd1})
      $display("FAIL ooo_first got %b/%0d/%h/%0d exp 1/3/11/1", commit_ena_to_reg,
               commit_rd_to_reg, commit_value_to_reg, commit_rob_id_to_reg);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({commit_ena_to_reg, commit_rd_to_reg, commit_value_to_reg, commit_rob_id_to_reg}
        !== {1'b1, 5'd4, 32'h22, 5'd2})
      $display("FAIL ooo_second got %b/%0d/%h/%0d exp 1/4/22/2", commit_ena_to_reg,
               commit_rd_to_reg, commit_value_to_reg, commit_rob_id_to_reg);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (commit_ena_to_reg !== 1'b0)
      $display("FAIL ooo_idle got %b exp 0", commit_ena_to_reg);
    else pass_cnt++;
  endtask

  task automatic test_store();
    do_reset();
    drive_dispatch(5'd0, 1'b0, 1'b1, 1'b0, 32'h3000);
    cycle();
    drive_ls(5'd1, 32'h0);
    cycle();
    cycle();
    total_cnt++;
    if ({commit_store_to_lsb, commit_rob_id_to_lsb, commit_ena_to_reg} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL store_commit got %b/%0d/%b exp 1/1/0", commit_store_to_lsb,
               commit_rob_id_to_lsb, commit_ena_to_reg);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (commit_store_to_lsb !== 1'b0)
      $display("FAIL store_pulse got %b exp 0", commit_store_to_lsb);
    else pass_cnt++;
  endtask

  task automatic test_branch_correct();
    do_reset();
    drive_dispatch(5'd1, 1'b1, 1'b0, 1'b1, 32'h40);
    cycle();
    drive_rs(5'd1, 32'h44, 1'b1, 32'h80);
    cycle();
    cycle();
    total_cnt++;
    if ({commit_ena_to_reg, commit_rd_to_reg, commit_value_to_reg} !== {1'b1, 5'd1, 32'h44})
      $display("FAIL jal_link got %b/%0d/%h exp 1/1/44", commit_ena_to_reg,
               commit_rd_to_reg, commit_value_to_reg);
    else pass_cnt++;
    total_cnt++;
    if ({bp_ena, bp_pc, bp_taken, rollback_flag} !== {1'b1, 32'h40, 1'b1, 1'b0})
      $display("FAIL jal_bp got %b/%h/%b/%b exp 1/40/1/0", bp_ena, bp_pc, bp_taken,
               rollback_flag);
    else pass_cnt++;
  endtask

  task automatic test_mispredict();
    do_reset();
    drive_dispatch(5'd0, 1'b1, 1'b0, 1'b0, 32'h40);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(5'(i + 1), 1'b0, 1'b0, 1'b0, 32'h44 + 32'(4 * i));
      cycle();
    end
    drive_rs(5'd1, 32'h0, 1'b1, 32'h100);
    cycle();
    cycle();
    total_cnt++;
    if ({rollback_flag, target_pc_to_if} !== {1'b1, 32'h100})
      $display("FAIL rollback got %b/%h exp 1/100", rollback_flag, target_pc_to_if);
    else pass_cnt++;
    total_cnt++;
    if ({bp_ena, bp_pc, bp_taken, commit_ena_to_reg} !== {1'b1, 32'h40, 1'b1, 1'b0})
      $display("FAIL rollback_bp got %b/%h/%b/%b exp 1/40/1/0", bp_ena, bp_pc, bp_taken,
               commit_ena_to_reg);
    else pass_cnt++;
    total_cnt++;
    if ({rob_id_to_dsp, full_to_if} !== {5'd1, 1'b0})
      $display("FAIL rollback_ptrs got %0d/%b exp 1/0", rob_id_to_dsp, full_to_if);
    else pass_cnt++;
    // Wrong-path dispatch in the cycle the flush is visible is dropped.
    drive_dispatch(5'd7, 1'b0, 1'b0, 1'b0, 32'h48);
    cycle();
    total_cnt++;
    if ({rob_id_to_dsp, rollback_flag} !== {5'd1, 1'b0})
      $display("FAIL rollback_drop got %0d/%b exp 1/0", rob_id_to_dsp, rollback_flag);
    else pass_cnt++;
    drive_dispatch(5'd8, 1'b0, 1'b0, 1'b0, 32'h100);
    cycle();
    total_cnt++;
    if (rob_id_to_dsp !== 5'd2)
      $display("FAIL rollback_resume got %0d exp 2", rob_id_to_dsp);
    else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive_dispatch(5'd9, 1'b0, 1'b0, 1'b0, 32'h5000 + 32'(4 * i));
      cycle();
    end
    total_cnt++;
    if (full_to_if !== 1'b0)
      $display("FAIL full_13 got %b exp 0", full_to_if);
    else pass_cnt++;
    drive_dispatch(5'd9, 1'b0, 1'b0, 1'b0, 32'h5034);
    cycle();
    total_cnt++;
    if (full_to_if !== 1'b1)
      $display("FAIL full_14 got %b exp 1", full_to_if);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      drive_dispatch(5'd9, 1'b0, 1'b0, 1'b0, 32'h5038 + 32'(4 * i));
      cycle();
    end
    total_cnt++;
    if (rob_id_to_dsp !== 5'd1)
      $display("FAIL full_wrap_id got %0d exp 1", rob_id_to_dsp);
    else pass_cnt++;
    drive_rs(5'd1, 32'h55, 1'b0, 32'h0);
    cycle();
    // Commit id1 and dispatch into its slot on the same edge.
    drive_dispatch(5'd10, 1'b0, 1'b0, 1'b0, 32'h6000);
    cycle();
    Q1_from_dsp = 5'd1;
    #1;
    total_cnt++;
    if ({commit_ena_to_reg, commit_value_to_reg, commit_rob_id_to_reg} !== {1'b1, 32'h55, 5'd1})
      $display("FAIL wrap_commit got %b/%h/%0d exp 1/55/1", commit_ena_to_reg,
               commit_value_to_reg, commit_rob_id_to_reg);
    else pass_cnt++;
    total_cnt++;
    if ({rob_id_to_dsp, full_to_if, Q1_ready_to_dsp} !== {5'd2, 1'b1, 1'b0})
      $display("FAIL wrap_reuse got %0d/%b/%b exp 2/1/0", rob_id_to_dsp, full_to_if,
               Q1_ready_to_dsp);
    else pass_cnt++;
    // Reset in the middle of a full buffer.
    do_reset();
    total_cnt++;
    if ({rob_id_to_dsp, full_to_if} !== {5'd1, 1'b0})
      $display("FAIL midreset got %0d/%b exp 1/0", rob_id_to_dsp, full_to_if);
    else pass_cnt++;
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    drive_dispatch(5'd6, 1'b0, 1'b0, 1'b0, 32'h7000);
    cycle();
    drive_rs(5'd1, 32'h77, 1'b0, 32'h0);
    cycle();
    rdy = 1'b0;
    drive_dispatch(5'd6, 1'b0, 1'b0, 1'b0, 32'h7004);
    cycle();
    cycle();
    total_cnt++;
    if ({commit_ena_to_reg, rob_id_to_dsp} !== {1'b0, 5'd2})
      $display("FAIL freeze_hold got %b/%0d exp 0/2", commit_ena_to_reg, rob_id_to_dsp);
    else pass_cnt++;
    rdy = 1'b1;
    cycle();
    total_cnt++;
    if ({commit_ena_to_reg, commit_value_to_reg} !== {1'b1, 32'h77})
      $display("FAIL freeze_commit got %b/%h exp 1/77", commit_ena_to_reg, commit_value_to_reg);
    else pass_cnt++;
    rdy = 1'b0;
    cycle();
    total_cnt++;
    if (commit_ena_to_reg !== 1'b1)
      $display("FAIL freeze_pulse_held got %b exp 1", commit_ena_to_reg);
    else pass_cnt++;
    rdy = 1'b1;
    cycle();
    total_cnt++;
    if (commit_ena_to_reg !== 1'b0)
      $display("FAIL freeze_pulse_drop got %b exp 0", commit_ena_to_reg);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------
  // Main sequence and final report
  // ---------------------------------------------------------------------
  initial begin
    pass_cnt                = 0;
    total_cnt               = 0;
    rst                     = 1'b1;
    rdy                     = 1'b1;
    ena_from_dsp            = 1'b0;
    rd_from_dsp             = '0;
    is_jump_from_dsp        = 1'b0;
    is_store_from_dsp       = 1'b0;
    predicted_jump_from_dsp = 1'b0;
    pc_from_dsp             = '0;
    Q1_from_dsp             = '0;
    Q2_from_dsp             = '0;
    valid_from_rs_cdb       = 1'b0;
    rob_id_from_rs_cdb      = '0;
    result_from_rs_cdb      = '0;
    jump_flag_from_rs_cdb   = 1'b0;
    target_pc_from_rs_cdb   = '0;
    valid_from_ls_cdb       = 1'b0;
    rob_id_from_ls_cdb      = '0;
    result_from_ls_cdb      = '0;

    test_reset();
    test_single_commit();
    test_out_of_order();
    test_store();
    test_branch_correct();
    test_mispredict();
    test_full_wrap();
    test_rdy_freeze();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
